// File: rtl/stage3_types_pkg.sv
// Shared types for the 3-stage pipeline: the fetch->execute bundle and the fetch FSM states.
package stage3_types_pkg;

  typedef struct packed {
    logic        valid;
    logic        token;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] prediction;
    logic        fault_insn;
    logic        mal_insn;
    logic [31:0] badaddr;
  } fetch_ex_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/stage3_fetch_stage.sv
// Fetch stage: owns the PC, issues igen reads, applies prediction and presents
// fetch_ex_t to execute through a valid/ready output slot backed by a skid register.
module stage3_fetch_stage
  import stage3_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        predict_taken,
  input  logic [31:0] predict_target,
  output logic [31:0] pc_o,
  output logic        iren,
  output logic [31:0] iaddr,
  input  logic        ibusy,
  input  logic [31:0] irdata,
  input  logic        ierror,
  output fetch_ex_t   fetch_out
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  fetch_ex_t    skid;
  logic         pending;
  logic         armed;
  logic         mal_sent;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         aligned;
  logic         slot_open;
  logic         complete;
  fetch_ex_t    resp;
  fetch_ex_t    mal_resp;

  assign pc_o = pc;

  always_comb begin
    pc_plus4  = pc + 32'd4;
    next_pc   = predict_taken ? predict_target : pc_plus4;
    aligned   = (pc[1:0] == 2'b00);
    slot_open = !fetch_out.valid || ex_ready;

    iren  = 1'b0;
    iaddr = pc;
    unique case (state)
      // once a request is on the bus it stays there until completion, whatever the slot does
      FETCH:   iren = armed && (pending || (!halt && aligned && slot_open));
      DRAIN: begin
        iren  = 1'b1;
        iaddr = drain_addr;
      end
      default: iren = 1'b0;
    endcase
    complete = iren && !ibusy;

    resp            = '0;
    resp.valid      = 1'b1;
    resp.token      = 1'b1;
    resp.pc         = pc;
    resp.pc4        = pc_plus4;
    resp.instr      = irdata;
    resp.prediction = next_pc;
    resp.fault_insn = ierror;
    resp.badaddr    = ierror ? pc : '0;

    mal_resp            = '0;
    mal_resp.valid      = 1'b1;
    mal_resp.pc         = pc;
    mal_resp.pc4        = pc_plus4;
    mal_resp.prediction = pc;
    mal_resp.mal_insn   = 1'b1;
    mal_resp.badaddr    = pc;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      fetch_out  <= '0;
      skid       <= '0;
      pending    <= 1'b0;
      armed      <= 1'b0;
      mal_sent   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (ex_ready) fetch_out.valid <= 1'b0;

      if (redirect) begin
        pc         <= redirect_pc;
        fetch_out  <= '0;
        skid       <= '0;
        pending    <= 1'b0;
        mal_sent   <= 1'b0;
        drain_addr <= iaddr;
        state      <= (iren && ibusy) ? DRAIN : FETCH;
      end else begin
        unique case (state)
          FETCH: begin
            pending <= iren && ibusy;
            if (complete) begin
              pc <= next_pc;
              if (slot_open) begin
                fetch_out <= resp;
              end else begin
                skid  <= resp;
                state <= HOLD;
              end
            end else if (armed && !halt && !aligned && !mal_sent && slot_open) begin
              fetch_out <= mal_resp;
              mal_sent  <= 1'b1;
            end
          end
          DRAIN: begin
            if (complete) state <= FETCH;
          end
          HOLD: begin
            if (ex_ready) begin
              fetch_out <= skid;
              skid      <= '0;
              state     <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage3_fetch_stage.sv
// Bench for stage3_fetch_stage: directed scenarios plus a randomized run scored
// against an instruction-stream model of the program the fetch should deliver.
module tb_stage3_fetch_stage;
  import stage3_types_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [31:0] pc_o;
  logic        iren;
  logic [31:0] iaddr;
  logic        ibusy;
  logic [31:0] irdata;
  logic        ierror;
  fetch_ex_t   fetch_out;

  int unsigned chk_pass = 0;
  int unsigned chk_total = 0;

  int          pred_mode;
  int          busy_left;
  bit          rand_bus;
  bit          sb_on;
  logic [31:0] sb_pc;
  int          sb_n;
  logic [31:0] acc_log[$];

  stage3_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .nRST(nRST), .ex_ready(ex_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .predict_taken(predict_taken),
    .predict_target(predict_target), .pc_o(pc_o), .iren(iren), .iaddr(iaddr),
    .ibusy(ibusy), .irdata(irdata), .ierror(ierror), .fetch_out(fetch_out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic bus_err(input logic [31:0] a);
    return (a[11:0] == 12'h300) || (a[7:2] == 6'h2B);
  endfunction

  function automatic logic pred_taken_f(input logic [31:0] a);
    if (pred_mode == 1) return a == 32'h204;
    if (pred_mode == 2) return a[6:2] == 5'd13;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pred_target_f(input logic [31:0] a);
    if (pred_mode == 1) return 32'h400;
    return a + 32'h140;
  endfunction

  // environment: predictor and memory respond to whatever the DUT presents
  always_comb begin
    predict_taken  = pred_taken_f(pc_o);
    predict_target = pred_target_f(pc_o);
    irdata         = mem_word(iaddr);
    ierror         = bus_err(iaddr);
  end

  // one clock: settle inputs, capture pre-edge view, advance the bus model
  task automatic step();
    logic      p_iren;
    logic      p_acc;
    logic      p_redir;
    fetch_ex_t p_fo;
    fetch_ex_t e;
    ibusy = (busy_left != 0);
    #1;
    p_iren  = iren;
    p_fo    = fetch_out;
    p_acc   = fetch_out.valid && ex_ready;
    p_redir = redirect;
    if (p_acc && !p_redir) begin
      acc_log.push_back(p_fo.pc);
      if (sb_on) begin
        e            = '0;
        e.valid      = 1'b1;
        e.token      = 1'b1;
        e.pc         = sb_pc;
        e.pc4        = sb_pc + 32'd4;
        e.instr      = mem_word(sb_pc);
        e.prediction = pred_taken_f(sb_pc) ? pred_target_f(sb_pc) : sb_pc + 32'd4;
        e.fault_insn = bus_err(sb_pc);
        e.badaddr    = bus_err(sb_pc) ? sb_pc : 32'h0;
        chk_total++;
        if (p_fo !== e) $display("FAIL stream[%0d] got %h exp %h", sb_n, p_fo, e);
        else chk_pass++;
        sb_pc = e.prediction;
        sb_n++;
      end
    end
    @(posedge CLK);
    if (p_iren) begin
      if (busy_left == 0) busy_left = rand_bus ? int'($urandom_range(0, 2)) : 0;
      else busy_left--;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0; ex_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    busy_left = 0; ibusy = 1'b0; rand_bus = 1'b0; sb_on = 1'b0; pred_mode = 0;
    acc_log.delete();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic wait_iren(input string tag);
    int n = 0;
    while (!iren && n < 6) begin step(); n++; end
    chk_total++;
    if (iren !== 1'b1) $display("FAIL %s_timeout iren got %b exp 1", tag, iren);
    else chk_pass++;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ex_ready = 1'b0; redirect = 1'b0; halt = 1'b0; busy_left = 0;
    @(negedge CLK); #1;
    chk_total++;
    if (fetch_out !== '0 || pc_o !== RST_PC || iren !== 1'b0)
      $display("FAIL reset_state got fo=%h pc=%h iren=%b exp fo=0 pc=%h iren=0", fetch_out, pc_o, iren, RST_PC);
    else chk_pass++;
    do_reset();
    #1;
    chk_total++;
    if (iren !== 1'b0) $display("FAIL reset_first_cycle iren got %b exp 0", iren);
    else chk_pass++;
  endtask

  task automatic test_sequential();
    do_reset(); ex_ready = 1'b1;
    wait_iren("seq");
    chk_total++;
    if (iaddr !== 32'h200) $display("FAIL seq_iaddr0 got %h exp 200", iaddr); else chk_pass++;
    step();
    chk_total++;
    if (iaddr !== 32'h204 || iren !== 1'b1) $display("FAIL seq_iaddr1 got %h/%b exp 204/1", iaddr, iren); else chk_pass++;
    chk_total++;
    if (!fetch_out.valid || !fetch_out.token || fetch_out.pc !== 32'h200 || fetch_out.pc4 !== 32'h204 || fetch_out.instr !== mem_word(32'h200))
      $display("FAIL seq_out0 got %h exp pc=200 pc4=204", fetch_out);
    else chk_pass++;
    step();
    chk_total++;
    if (iaddr !== 32'h208 || fetch_out.pc !== 32'h204 || fetch_out.pc4 !== 32'h208 || !fetch_out.valid)
      $display("FAIL seq_out1 got iaddr=%h pc=%h pc4=%h exp 208/204/208", iaddr, fetch_out.pc, fetch_out.pc4);
    else chk_pass++;
    step();
    chk_total++;
    if (fetch_out.pc !== 32'h208 || fetch_out.pc4 !== 32'h20C) $display("FAIL seq_out2 got %h/%h exp 208/20c", fetch_out.pc, fetch_out.pc4);
    else chk_pass++;
  endtask

  task automatic test_predict();
    do_reset(); ex_ready = 1'b1; pred_mode = 1;
    wait_iren("pred");
    step(); step();
    chk_total++;
    if (fetch_out.pc !== 32'h204 || fetch_out.prediction !== 32'h400 || iaddr !== 32'h400)
      $display("FAIL predict got pc=%h pred=%h iaddr=%h exp 204/400/400", fetch_out.pc, fetch_out.prediction, iaddr);
    else chk_pass++;
  endtask

  task automatic test_drain();
    bit seen_208 = 1'b0;
    do_reset(); ex_ready = 1'b1;
    wait_iren("drain");
    step(); step();
    chk_total++;
    if (iaddr !== 32'h208) $display("FAIL drain_setup iaddr got %h exp 208", iaddr); else chk_pass++;
    busy_left = 3;
    step();
    redirect = 1'b1; redirect_pc = 32'h800;
    step();
    redirect = 1'b0;
    chk_total++;
    if (iren !== 1'b1 || iaddr !== 32'h208 || pc_o !== 32'h800 || fetch_out.valid !== 1'b0)
      $display("FAIL drain_hold got iren=%b iaddr=%h pc=%h v=%b exp 1/208/800/0", iren, iaddr, pc_o, fetch_out.valid);
    else chk_pass++;
    step();
    chk_total++;
    if (iren !== 1'b1 || iaddr !== 32'h208) $display("FAIL drain_hold2 got %b/%h exp 1/208", iren, iaddr); else chk_pass++;
    step();
    chk_total++;
    if (iren !== 1'b1 || iaddr !== 32'h800 || fetch_out.valid !== 1'b0)
      $display("FAIL drain_exit got iren=%b iaddr=%h v=%b exp 1/800/0", iren, iaddr, fetch_out.valid);
    else chk_pass++;
    step();
    chk_total++;
    if (!fetch_out.valid || fetch_out.pc !== 32'h800) $display("FAIL drain_newpc got v=%b pc=%h exp 1/800", fetch_out.valid, fetch_out.pc);
    else chk_pass++;
    foreach (acc_log[i]) if (acc_log[i] == 32'h208) seen_208 = 1'b1;
    chk_total++;
    if (seen_208) $display("FAIL drain_dropped got 208 delivered exp none"); else chk_pass++;
  endtask

  task automatic test_stall_in_order();
    do_reset(); ex_ready = 1'b1;
    wait_iren("stall");
    step();
    ex_ready = 1'b0; #1;
    chk_total++;
    if (iren !== 1'b0) $display("FAIL stall_full_noissue iren got %b exp 0", iren); else chk_pass++;
    ex_ready = 1'b1; busy_left = 2;
    step();
    ex_ready = 1'b0;
    step(); step();
    chk_total++;
    if (iren !== 1'b0 || !fetch_out.valid || fetch_out.pc !== 32'h204)
      $display("FAIL stall_held got iren=%b v=%b pc=%h exp 0/1/204", iren, fetch_out.valid, fetch_out.pc);
    else chk_pass++;
    step();
    chk_total++;
    if (iren !== 1'b0 || fetch_out.pc !== 32'h204) $display("FAIL stall_stable got %b/%h exp 0/204", iren, fetch_out.pc); else chk_pass++;
    ex_ready = 1'b1;
    repeat (3) step();
    chk_total++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h200 || acc_log[1] !== 32'h204 || acc_log[2] !== 32'h208)
      $display("FAIL stall_order got n=%0d first=%h exp 200,204,208", acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    else chk_pass++;
  endtask

  task automatic test_misaligned();
    do_reset(); ex_ready = 1'b1;
    wait_iren("mal");
    redirect = 1'b1; redirect_pc = 32'h802;
    step();
    redirect = 1'b0;
    chk_total++;
    if (pc_o !== 32'h802 || iren !== 1'b0) $display("FAIL mal_noreq got pc=%h iren=%b exp 802/0", pc_o, iren); else chk_pass++;
    step();
    chk_total++;
    if (!fetch_out.valid || !fetch_out.mal_insn || fetch_out.token || fetch_out.badaddr !== 32'h802 || fetch_out.instr !== 32'h0)
      $display("FAIL mal_out got %h exp valid=1 mal=1 token=0 badaddr=802 instr=0", fetch_out);
    else chk_pass++;
    step(); step();
    chk_total++;
    if (iren !== 1'b0 || pc_o !== 32'h802) $display("FAIL mal_held got iren=%b pc=%h exp 0/802", iren, pc_o); else chk_pass++;
  endtask

  task automatic test_fault_and_wrap();
    do_reset(); ex_ready = 1'b1;
    wait_iren("fault");
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    step();
    chk_total++;
    if (!fetch_out.valid || !fetch_out.fault_insn || fetch_out.badaddr !== 32'h300 || fetch_out.pc !== 32'h300)
      $display("FAIL fault_out got %h exp valid=1 fault=1 badaddr=300", fetch_out);
    else chk_pass++;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk_total++;
    if (iaddr !== 32'hFFFF_FFFC || iren !== 1'b1) $display("FAIL wrap_issue got %h/%b exp fffffffc/1", iaddr, iren); else chk_pass++;
    step();
    chk_total++;
    if (fetch_out.pc4 !== 32'h0 || iaddr !== 32'h0 || fetch_out.fault_insn)
      $display("FAIL wrap_pc4 got pc4=%h iaddr=%h f=%b exp 0/0/0", fetch_out.pc4, iaddr, fetch_out.fault_insn);
    else chk_pass++;
  endtask

  task automatic test_halt();
    do_reset(); ex_ready = 1'b1; halt = 1'b1;
    repeat (3) step();
    chk_total++;
    if (iren !== 1'b0 || pc_o !== RST_PC) $display("FAIL halt_block got iren=%b pc=%h exp 0/%h", iren, pc_o, RST_PC); else chk_pass++;
    halt = 1'b0; #1;
    chk_total++;
    if (iren !== 1'b1 || iaddr !== RST_PC) $display("FAIL halt_resume got %b/%h exp 1/%h", iren, iaddr, RST_PC); else chk_pass++;
  endtask

  task automatic test_random_stream();
    do_reset(); pred_mode = 2; rand_bus = 1'b1; sb_on = 1'b1; sb_pc = RST_PC; sb_n = 0;
    for (int i = 0; i < 800; i++) begin
      ex_ready = ($urandom_range(0, 9) < 7);
      halt     = ($urandom_range(0, 19) == 0);
      step();
    end
    halt = 1'b0; ex_ready = 1'b1;
    repeat (6) step();
    chk_total++;
    if (sb_n < 80) $display("FAIL rand_liveness got %0d delivered exp >= 80", sb_n); else chk_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(); ex_ready = 1'b1;
    wait_iren("areset");
    step(); step();
    busy_left = 3;
    step();
    #2 nRST = 1'b0;
    #1;
    chk_total++;
    if (fetch_out !== '0 || pc_o !== RST_PC || iren !== 1'b0)
      $display("FAIL async_reset got fo=%h pc=%h iren=%b exp 0/%h/0", fetch_out, pc_o, iren, RST_PC);
    else chk_pass++;
    busy_left = 0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_drain();
    test_stall_in_order();
    test_misaligned();
    test_fault_and_wrap();
    test_halt();
    test_random_stream();
    test_async_reset();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
